aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Sequential, parametrised AES key-expansion engine that succeeds the combinational single-round key generator. It accepts a 128-, 192- or 256-bit cipher key and computes the full FIPS-197 key schedule one 32-bit word per cycle into an internal round-key store. The round cipher then reads any round key through a registered read port. It sits between the key-load interface and the AES round datapath.

## Interface
Parameters:
- KEY_BITS, 128, cipher key size; legal values are 128, 192 and 256. Derived: NK = KEY_BITS/32, NR = NK+6, NW = 4*(NR+1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  new key offered
- key_ready  out  1  engine can accept a key
- key  in  KEY_BITS  cipher key; w[0] is in key[KEY_BITS-1 -: 32]
- busy  out  1  expansion in progress
- sched_valid  out  1  full schedule available
- rd_round  in  4  round-key index, 0..NR
- rd_key  out  128  round key rd_round, registered; {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs
- rd_inv  in  1  present only when AES_KEY_SCHED_INV_EN is defined

## Operation
- FSM states:
  - IDLE (after reset): key_ready=1.
  - EXPAND: busy=1, key_ready=0.
  - READY: key_ready=1, sched_valid=1.
- Key accept: key_valid && key_ready moves the FSM to EXPAND.
  - The same cycle writes w[0..NK-1] from key, sets index i=NK and sets rcon=8'h01.
- EXPAND, each cycle:
  - t = w[i-1].
  - If i mod NK == 0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}, then rcon = xtime(rcon).
  - Else if NK==8 and i mod 8 == 4: t = SubWord(t).
  - Write w[i] = w[i-NK] ^ t, then i = i+1.
  - After writing w[NW-1], go to READY.
- SubWord uses four combinational S-box instances.
- xtime(x) = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00).
- Rekey from READY: accept is allowed. sched_valid drops the cycle after acceptance, and the old schedule is overwritten.
- key_valid while in EXPAND is ignored; it is not queued.
- Read port:
  - rd_key <= sched_valid ? store[rd_round] : 128'h0.
  - rd_round > NR returns 128'h0.
- Reset at any time, including mid-expansion: returns to IDLE. The store contents do not matter because reads are gated by sched_valid.

## Timing
- Output reset values: key_ready=1, busy=0, sched_valid=0, rd_key=128'h0.
- Expansion latency, counted from the accept edge to sched_valid=1: NW-NK cycles.
  - 40 for KEY_BITS=128.
  - 46 for KEY_BITS=192.
  - 52 for KEY_BITS=256.
- Read latency is 1 cycle: rd_round sampled at edge n appears on rd_key after edge n.
- A read issued on the same edge that a rekey is accepted returns the old key. Reads on any later edge return 0 until the new schedule completes.

## Configuration
- AES_KEY_SCHED_INV_EN defined:
  - Adds the rd_inv port.
  - With rd_inv=1 and 1 <= rd_round <= NR-1, rd_key = InvMixColumns(store[rd_round]), giving equivalent-inverse-cipher keys.
  - Rounds 0 and NR are unchanged.
  - The transform sits in the combinational read path ahead of the rd_key register, so latency stays 1 cycle.
- AES_KEY_SCHED_INV_EN undefined: no rd_inv port, no InvMixColumns logic, and rd_key is always the forward key.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - sched_valid rises exactly 40 cycles after accept.
  - Round 1 reads a0fafe1788542cb123a339392a6c7605.
  - Round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - Latency is 46 cycles.
  - Round 12 reads e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - Latency is 52 cycles.
  - Round 14 reads fe4890d1e6188d0b046df344706c631e.
  - Checks the i mod 8 == 4 SubWord path.
- Reset and rekey during expansion (128-bit):
  - Assert rst at cycle 20 of expansion: key_ready=1, sched_valid=0 and rd_key=0 on the next cycle.
  - Re-offer the key: the full 40-cycle expansion repeats and round 10 is correct.
  - key_valid pulsed mid-expansion is ignored: the round keys match the first key.
- Boundary reads:
  - rd_round=11 with KEY_BITS=128 returns 0.
  - Any read before sched_valid returns 0.
  - Rekey from READY: sched_valid falls one cycle after accept.
- With AES_KEY_SCHED_INV_EN (128-bit FIPS key):
  - rd_inv=1, rd_round=0 and rd_round=10 return the forward keys.
  - rd_inv=1, rd_round=5 equals InvMixColumns of the forward round-5 key, checked against a bench model.

Source files
------------

// File: rtl/aes_key_schedule.sv
`default_nettype none
//==============================================================================
// Module   : aes_key_schedule
// Summary  : Sequential AES-128/192/256 key expansion (one word per cycle) into
//            a round-key store with a registered read port. Define
//            AES_KEY_SCHED_INV_EN to add rd_inv (equivalent-inverse-cipher keys).
// Revision : 1.0
//==============================================================================
module aes_key_schedule #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key,
    output logic                busy,
    output logic                sched_valid,
    input  logic [3:0]          rd_round,
`ifdef AES_KEY_SCHED_INV_EN
    input  logic                rd_inv,
`endif
    output logic [127:0]        rd_key
);
    localparam int         c_nk        = KEY_BITS / 32;
    localparam int         c_nr        = c_nk + 6;
    localparam int         c_nw        = 4 * (c_nr + 1);
    localparam logic [5:0] c_idx_first = 6'(c_nk);
    localparam logic [5:0] c_idx_last  = 6'(c_nw - 1);
    localparam logic [3:0] c_mod_last  = 4'(c_nk - 1);
    localparam logic [3:0] c_nr_w      = 4'(c_nr);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    function automatic logic [7:0] f_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = f_xtime(aa);
        end
        return p;
    endfunction

    // S-box as x^254 in GF(2^8) followed by the affine map (0 maps to 0 before affine).
    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = f_gmul(sq, sq);
            inv = f_gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

`ifdef AES_KEY_SCHED_INV_EN
    function automatic logic [31:0] f_inv_mix_col(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = c;
        return {f_gmul(b0, 8'h0e) ^ f_gmul(b1, 8'h0b) ^ f_gmul(b2, 8'h0d) ^ f_gmul(b3, 8'h09),
                f_gmul(b0, 8'h09) ^ f_gmul(b1, 8'h0e) ^ f_gmul(b2, 8'h0b) ^ f_gmul(b3, 8'h0d),
                f_gmul(b0, 8'h0d) ^ f_gmul(b1, 8'h09) ^ f_gmul(b2, 8'h0e) ^ f_gmul(b3, 8'h0b),
                f_gmul(b0, 8'h0b) ^ f_gmul(b1, 8'h0d) ^ f_gmul(b2, 8'h09) ^ f_gmul(b3, 8'h0e)};
    endfunction
`endif

    state_t      r_state;
    logic        r_key_ready;
    logic        r_busy;
    logic        r_sched_valid;
    logic [5:0]  r_idx;
    logic [3:0]  r_mod;
    logic [7:0]  r_rcon;
    logic [31:0] r_w [0:c_nw-1];
    logic [127:0] r_rd_key;

    logic        w_accept;
    logic [31:0] w_prev;
    logic [31:0] w_back;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub;
    logic [31:0] w_t;
    logic        w_rd_ok;
    logic [5:0]  w_base;
    logic [127:0] w_rd_word;
    logic [127:0] w_rd_next;

    assign w_accept = key_valid && r_key_ready;
    assign w_prev   = r_w[r_idx - 6'd1];
    assign w_back   = r_w[r_idx - c_idx_first];
    assign w_sub_in = (r_mod == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign w_sub[8*b +: 8] = f_sbox(w_sub_in[8*b +: 8]);
    end

    always_comb begin
        w_t = w_prev;
        if (r_mod == 4'd0) begin
            w_t = w_sub ^ {r_rcon, 24'h000000};
        end else if (c_nk == 8 && r_mod == 4'd4) begin
            w_t = w_sub;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_key_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_sched_valid <= 1'b0;
            r_idx         <= 6'd0;
            r_mod         <= 4'd0;
            r_rcon        <= 8'h01;
        end else begin
            case (r_state)
                ST_IDLE, ST_READY: begin
                    if (w_accept) begin
                        r_state       <= ST_EXPAND;
                        r_key_ready   <= 1'b0;
                        r_busy        <= 1'b1;
                        r_sched_valid <= 1'b0;
                        r_idx         <= c_idx_first;
                        r_mod         <= 4'd0;
                        r_rcon        <= 8'h01;
                    end
                end
                ST_EXPAND: begin
                    r_idx <= r_idx + 6'd1;
                    r_mod <= (r_mod == c_mod_last) ? 4'd0 : r_mod + 4'd1;
                    if (r_mod == 4'd0) r_rcon <= f_xtime(r_rcon);
                    if (r_idx == c_idx_last) begin
                        r_state       <= ST_READY;
                        r_key_ready   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_sched_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_key_ready   <= 1'b1;
                    r_busy        <= 1'b0;
                    r_sched_valid <= 1'b0;
                end
            endcase
        end
    end

    // Store is left unreset: every read is gated by sched_valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < c_nk; k++) begin
                r_w[k] <= key[KEY_BITS-1-32*k -: 32];
            end
        end else if (r_state == ST_EXPAND) begin
            r_w[r_idx] <= w_back ^ w_t;
        end
    end

    assign w_rd_ok   = (rd_round <= c_nr_w);
    assign w_base    = w_rd_ok ? {rd_round, 2'b00} : 6'd0;
    assign w_rd_word = {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};

`ifdef AES_KEY_SCHED_INV_EN
    // First and last round keys are used untransformed by the equivalent inverse cipher.
    always_comb begin
        w_rd_next = w_rd_word;
        if (rd_inv && rd_round != 4'd0 && rd_round < c_nr_w) begin
            w_rd_next = {f_inv_mix_col(w_rd_word[127:96]), f_inv_mix_col(w_rd_word[95:64]),
                         f_inv_mix_col(w_rd_word[63:32]),  f_inv_mix_col(w_rd_word[31:0])};
        end
    end
`else
    assign w_rd_next = w_rd_word;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_key <= 128'h0;
        end else begin
            r_rd_key <= (r_sched_valid && w_rd_ok) ? w_rd_next : 128'h0;
        end
    end

    assign key_ready   = r_key_ready;
    assign busy        = r_busy;
    assign sched_valid = r_sched_valid;
    assign rd_key      = r_rd_key;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
//==============================================================================
// Module   : tb_aes_key_schedule
// Summary  : Self-checking bench for aes_key_schedule (128/192/256-bit instances),
//            scoreboard of expected round-key reads against an independent model.
// Revision : 1.0
//==============================================================================
module tb_aes_key_schedule;
    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [255:0] kin;
    logic [3:0]   rd_round;
    logic         rd_inv;
    int           sel;

    logic         kr [3];
    logic         bz [3];
    logic         sv [3];
    logic [127:0] rk [3];
    logic         key_ready_m, busy_m, sched_valid_m;
    logic [127:0] rd_key_m;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string        tag;
        logic [127:0] exp;
    } sb_t;
    sb_t sb_q[$];

    logic [31:0] m_w [0:59];
    logic        mv;

    always #5 clk = ~clk;

    aes_key_schedule #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst(rst), .key_valid(key_valid && sel == 0), .key_ready(kr[0]),
        .key(kin[255 -: 128]), .busy(bz[0]), .sched_valid(sv[0]), .rd_round(rd_round),
`ifdef AES_KEY_SCHED_INV_EN
        .rd_inv(rd_inv),
`endif
        .rd_key(rk[0]));

    aes_key_schedule #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst(rst), .key_valid(key_valid && sel == 1), .key_ready(kr[1]),
        .key(kin[255 -: 192]), .busy(bz[1]), .sched_valid(sv[1]), .rd_round(rd_round),
`ifdef AES_KEY_SCHED_INV_EN
        .rd_inv(rd_inv),
`endif
        .rd_key(rk[1]));

    aes_key_schedule #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst(rst), .key_valid(key_valid && sel == 2), .key_ready(kr[2]),
        .key(kin), .busy(bz[2]), .sched_valid(sv[2]), .rd_round(rd_round),
`ifdef AES_KEY_SCHED_INV_EN
        .rd_inv(rd_inv),
`endif
        .rd_key(rk[2]));

    always_comb begin
        key_ready_m   = kr[sel];
        busy_m        = bz[sel];
        sched_valid_m = sv[sel];
        rd_key_m      = rk[sel];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: carry-less product then polynomial reduction.
    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        inv = 8'h00;
        c   = 8'h63;
        if (x != 8'h00)
            for (int y = 1; y < 256; y++) if (m_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [31:0] m_subword(input logic [31:0] t);
        return {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) m_w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = m_w[i-1];
            if (i % nk == 0) begin
                t  = m_subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = m_gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = m_subword(t);
            end
            m_w[i] = m_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] m_invmix(input logic [127:0] x);
        logic [127:0] o;
        logic [7:0]   b [4];
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) b[j] = x[127-32*c-8*j -: 8];
            for (int j = 0; j < 4; j++)
                o[127-32*c-8*j -: 8] = m_gmul(b[j], 8'h0e) ^ m_gmul(b[(j+1)%4], 8'h0b)
                                     ^ m_gmul(b[(j+2)%4], 8'h0d) ^ m_gmul(b[(j+3)%4], 8'h09);
        end
        return o;
    endfunction

    function automatic logic [127:0] exp_read(input int r, input logic inv);
        int nr;
        logic [127:0] k;
        nr = 4 + 2*sel + 6;
        if (!mv || r > nr) return 128'h0;
        k = {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
        if (inv && r >= 1 && r < nr) return m_invmix(k);
        return k;
    endfunction

    task automatic sb_pop_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 128'h1, 128'h0);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, rd_key_m, e.exp);
        end
    endtask

    task automatic read_one(input int r, input logic inv, input string tag, input logic [127:0] exp);
        rd_round = 4'(r);
        rd_inv   = inv;
        sb_q.push_back('{tag, exp});
        @(posedge clk); #1;
        sb_pop_check();
    endtask

    task automatic read_burst(input int first, input int last, input logic inv);
        for (int r = first; r <= last; r++)
            read_one(r, inv, $sformatf("rd_s%0d_r%0d_i%0d", sel, r, inv), exp_read(r, inv));
    endtask

    task automatic load_key(input logic [255:0] k, input int rst_at, input int pulse_at);
        int cyc;
        int nk;
        nk = 4 + 2*sel;
        chk("ready_pre", key_ready_m, 1);
        kin       = k;
        key_valid = 1'b1;
        rd_round  = 4'(nk + 6);
        rd_inv    = 1'b0;
        // Read on the accept edge still sees the previous schedule.
        sb_q.push_back('{"rd_on_accept", exp_read(nk + 6, 1'b0)});
        @(posedge clk); #1;
        key_valid = 1'b0;
        sb_pop_check();
        mv = 1'b0;
        model_expand(nk, k);
        chk("busy_acc", busy_m, 1);
        chk("ready_acc", key_ready_m, 0);
        chk("sv_acc", sched_valid_m, 0);
        cyc = 0;
        while (!sched_valid_m && cyc < 200) begin
            if (cyc == pulse_at) begin
                kin       = ~k;
                key_valid = 1'b1;
            end
            if (cyc == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            cyc++;
            key_valid = 1'b0;
            kin       = k;
            if (cyc == 1) chk("rd_during_exp", rd_key_m, 128'h0);
            if (rst) begin
                rst = 1'b0;
                chk("rst_ready", key_ready_m, 1);
                chk("rst_sv", sched_valid_m, 0);
                chk("rst_busy", busy_m, 0);
                chk("rst_rdkey", rd_key_m, 128'h0);
                return;
            end
        end
        chk("latency", 128'(cyc), 128'(4*(nk+7) - nk));
        chk("busy_done", busy_m, 0);
        mv = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] k128, k128b, k192, k256;
        k128  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k128b = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        k192  = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        sel = 0; mv = 1'b0; rst = 1'b1; key_valid = 1'b0; kin = '0; rd_round = '0; rd_inv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            chk($sformatf("reset_ready_%0d", s), key_ready_m, 1);
            chk($sformatf("reset_busy_%0d", s), busy_m, 0);
            chk($sformatf("reset_sv_%0d", s), sched_valid_m, 0);
            chk($sformatf("reset_rdkey_%0d", s), rd_key_m, 128'h0);
        end
        sel = 0;
        read_one(0, 1'b0, "rd_before_key", 128'h0);

        // AES-128 with a key_valid pulse mid-expansion that must be ignored.
        load_key(k128, -1, 10);
        read_burst(0, 11, 1'b0);
        read_one(1, 1'b0, "fips128_r1", 128'ha0fafe1788542cb123a339392a6c7605);
        read_one(10, 1'b0, "fips128_r10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_one(11, 1'b0, "rd_r11_128", 128'h0);

        // Rekey from READY, reset at cycle 20, then a full re-expansion.
        load_key(k128, 20, -1);
        load_key(k128, -1, -1);
        read_one(10, 1'b0, "fips128_r10_again", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef AES_KEY_SCHED_INV_EN
        read_burst(0, 10, 1'b1);
        read_one(0, 1'b1, "inv_r0_fwd", 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_one(10, 1'b1, "inv_r10_fwd", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_one(5, 1'b1, "inv_r5", m_invmix(128'hd4d1c6f87c839d87caf2b8bc11f915bc));
`endif
        load_key(k128b, -1, -1);
        read_one(10, 1'b0, "c1_128_r10", 128'h13111d7fe3944a17f307a78b4d2b30c5);
        read_burst(0, 11, 1'b0);

        sel = 1; mv = 1'b0;
        load_key(k192, -1, -1);
        read_burst(0, 13, 1'b0);
        read_one(12, 1'b0, "fips192_r12", 128'he98ba06f448c773c8ecc720401002202);

        sel = 2; mv = 1'b0;
        load_key(k256, -1, -1);
        read_burst(0, 15, 1'b0);
        read_one(14, 1'b0, "fips256_r14", 128'hfe4890d1e6188d0b046df344706c631e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
